shift_unit_seq: RTL and testbench
=================================

Name: shift_unit_seq

Overview:
- Parametrised, multi-cycle successor to the RV32 combinational logical-right shifter.
- Performs SLL, SRL and SRA on an XLEN-bit operand, resolving BITS_PER_CYCLE shift-amount bits per clock (an iterative log-shifter).
- Uses a valid/ready handshake on both input and output, plus a synchronous flush.
- Sits beside the ALU in the execute stage for area-constrained configurations, where a full barrel shifter is too large.

Parameters:
- XLEN, 32, operand/result width (power of two, ≥8).
- SHAMT_W, $clog2(XLEN), number of shift-amount bits consumed per operation.
- BITS_PER_CYCLE, 1, shift-amount bits resolved per cycle (1..SHAMT_W).
- SATURATE, 1: shamt ≥ XLEN gives full shift-out (0, or sign fill for SRA). 0: shamt masked to its low SHAMT_W bits (RISC-V semantics).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight operation.
- in_valid  in  1  operand request.
- in_ready  out  1  unit can accept a request.
- X  in  XLEN  operand.
- shift  in  XLEN  shift amount (full register value).
- op  in  2  00=SLL, 01=SRL, 11=SRA, 10=reserved.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  shifted value.
- op_err  out  1  result came from a reserved op (qualified by out_valid).

Behaviour:
- **Reset.** Asynchronous on rst_n low, at any time including mid-operation. State→IDLE; result=0, out_valid=0, op_err=0, in_ready=0 while rst_n low, 1 in IDLE afterwards.
- **Derived constant.** NSTEP = ceil(SHAMT_W/BITS_PER_CYCLE).
- **IDLE.** in_ready=1. On in_valid&in_ready, capture:
  - X into the working register;
  - op;
  - shamt = shift[SHAMT_W-1:0];
  - big = |shift[XLEN-1:SHAMT_W] (forced 0 when SATURATE=0).
  - Reserved op: go directly to DONE with result=0 and op_err=1.
  - Otherwise go to BUSY with step counter=0.
- **BUSY.** in_ready=0. Each cycle, for each bit k resolved this step: if shamt bit k is set, shift the working register by 2^k.
  - SLL: zero fill at the LSB end.
  - SRL: zero fill at the MSB end.
  - SRA: fill with original X[XLEN-1].
  - Bits are processed LSB first. The counter increments; after step NSTEP-1, go to DONE.
  - If big=1 the final result is overridden: 0 for SLL/SRL, {XLEN{X[XLEN-1]}} for SRA.
- **DONE.** out_valid=1 and result stable until out_ready=1. Then out_valid→0 and state→IDLE next cycle.
  - No new request is accepted in the handshake cycle (in_ready=0 in DONE).
- **Latency.** Accept edge to out_valid = NSTEP+1 cycles for valid ops; 1 cycle for reserved ops.
- **Throughput.** One operation per NSTEP+2 cycles with out_ready held high.
- **Fixed latency.** Latency does not depend on the shift amount; shamt=0 still takes NSTEP steps.
- **flush.**
  - In any state: next state IDLE, out_valid=0, op_err=0.
  - The working register is not cleared; result holds its last value and is don't-care when out_valid=0.
  - flush takes priority over in_valid and out_ready in the same cycle, and any request presented in that cycle is not accepted.
- **Output stability.** result, op_err and out_valid do not change while out_valid=1 and out_ready=0.
- **Backpressure.** in_valid asserted during BUSY/DONE is ignored; the requester must hold it until in_ready=1.

Decomposition:
- Shared package shift_pkg holds:
  - op encodings SH_SLL, SH_SRL, SH_SRA, SH_RSV;
  - state enum IDLE/BUSY/DONE;
  - a function computing NSTEP.
- One sub-module, shift_step: purely combinational.
  - Inputs: working value, shamt slice, step index, op, fill bit.
  - Output: the value shifted by the selected powers of two.
  - Instantiated once and reused each cycle.
- Top-level shift_unit_seq holds the FSM, counter, capture registers and saturation override.

Test Plan:
1. XLEN=32, BITS_PER_CYCLE=1, SATURATE=1; X=0x00000001, shift=2, op=SRL → out_valid 6 cycles after accept, result=0x00000000. Repeat with op=SLL → result=0x00000004.
2. X=0x80000000, shift=31: SRL → 0x00000001; SRA → 0xFFFFFFFF. Also X=0xA5A5A5A5, shift=16, SRA → 0xFFFFA5A5.
3. X=0x12345678, shift=0x20: SATURATE=1, SRL → 0x00000000 and SRA of 0x80000000 → 0xFFFFFFFF. SATURATE=0, SRL → 0x12345678 (shift masked to 0).
4. X=0xFFFFFFFF, shift=0 → result=0xFFFFFFFF after full latency. op=10 → out_valid 1 cycle after accept, result=0, op_err=1.
5. out_ready held low 10 cycles → result/out_valid stable and in_ready=0 throughout. Release → IDLE, in_ready=1 next cycle. Back-to-back stream of 4 ops with out_ready=1 matches a reference model.
6. Assert flush during BUSY step 2, and separately deassert rst_n asynchronously mid-BUSY → IDLE, out_valid=0 (reset also gives result=0). The next op X=0x55555555, shift=1, SRL → 0x2AAAAAAA. BITS_PER_CYCLE=2 and 5 give latencies 4 and 2 with identical results.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings, FSM states and step-count helper
// for the iterative shift unit.
package shift_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;
  localparam logic [1:0] SH_RSV = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int calc_nstep(
    input int shamt_w,
    input int bpc
  );
    return (shamt_w + bpc - 1) / bpc;
  endfunction

endpackage

// File: rtl/shift_unit_seq_step.sv
// One log-shifter slice: applies the 2^k shifts selected
// by the shamt bits belonging to the current step.
module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5,
  parameter int BPC     = 1,
  parameter int CNT_W   = 3
) (
  input  logic [XLEN-1:0]    val,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [CNT_W-1:0]   step,
  input  logic [1:0]         op,
  input  logic               fill,
  output logic [XLEN-1:0]    res
);

  localparam logic [XLEN-1:0] ONES = '1;

  logic [SHAMT_W-1:0] bits;
  int                 base;

  always_comb begin
    base = int'(step) * BPC;
    bits = shamt >> base;
    res  = val;
    for (int k = 0; k < BPC; k++) begin
      if (bits[k]) begin
        unique case (op)
          SH_SLL: res = res << (1 << (base + k));
          SH_SRA: res = (res >> (1 << (base + k)))
                      | ({XLEN{fill}}
                      & ~(ONES >> (1 << (base + k))));
          default: res = res >> (1 << (base + k));
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRL/SRA unit with valid/ready on both
// sides, synchronous flush and optional saturation.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int SHAMT_W        = $clog2(XLEN),
  parameter int BITS_PER_CYCLE = 1,
  parameter int SATURATE       = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] shift,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            op_err
);

  localparam int NSTEP = calc_nstep(SHAMT_W, BITS_PER_CYCLE);
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  state_t             state, state_n;
  logic [XLEN-1:0]    work, step_out;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [CNT_W-1:0]   cnt;
  logic               big_q, fill_q, err_q;
  logic               last, accept, rsv;

  assign in_ready  = rst_n & (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = work;
  assign op_err    = err_q;
  assign rsv       = (op == SH_RSV);
  assign accept    = in_valid & in_ready & ~flush;
  assign last      = (state == BUSY)
                   & (cnt == CNT_W'(NSTEP - 1));

  shift_step #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W),
    .BPC     (BITS_PER_CYCLE),
    .CNT_W   (CNT_W)
  ) u_step (
    .val   (work),
    .shamt (shamt_q),
    .step  (cnt),
    .op    (op_q),
    .fill  (fill_q),
    .res   (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      state == IDLE:
        if (in_valid) state_n = rsv ? DONE : BUSY;
      state == BUSY:
        if (last) state_n = DONE;
      state == DONE:
        if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      op_q    <= SH_SLL;
      shamt_q <= '0;
      big_q   <= 1'b0;
      fill_q  <= 1'b0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        work    <= rsv ? '0 : X;
        op_q    <= op;
        shamt_q <= shift[SHAMT_W-1:0];
        big_q   <= (SATURATE != 0)
                 & (|shift[XLEN-1:SHAMT_W]);
        fill_q  <= X[XLEN-1];
        cnt     <= '0;
        err_q   <= rsv;
      end
      // Oversized shift overrides only the final write.
      if (state == BUSY) begin
        cnt  <= cnt + 1'b1;
        work <= (last && big_q)
              ? {XLEN{fill_q & (op_q == SH_SRA)}}
              : step_out;
      end
      if (state == DONE && out_ready) err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq across saturate and
// bits-per-cycle variants.
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] X = '0;
  logic [31:0] shift = '0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  irdy, ov, oerr;
  logic [31:0] res [4];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          exp_lat [4] = '{6, 6, 4, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_unit_seq #(.XLEN(32), .BITS_PER_CYCLE(1),
                   .SATURATE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[0]),
    .X(X), .shift(shift), .op(op),
    .out_valid(ov[0]), .out_ready(out_ready),
    .result(res[0]), .op_err(oerr[0]));

  shift_unit_seq #(.XLEN(32), .BITS_PER_CYCLE(1),
                   .SATURATE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[1]),
    .X(X), .shift(shift), .op(op),
    .out_valid(ov[1]), .out_ready(out_ready),
    .result(res[1]), .op_err(oerr[1]));

  shift_unit_seq #(.XLEN(32), .BITS_PER_CYCLE(2),
                   .SATURATE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[2]),
    .X(X), .shift(shift), .op(op),
    .out_valid(ov[2]), .out_ready(out_ready),
    .result(res[2]), .op_err(oerr[2]));

  shift_unit_seq #(.XLEN(32), .BITS_PER_CYCLE(5),
                   .SATURATE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[3]),
    .X(X), .shift(shift), .op(op),
    .out_valid(ov[3]), .out_ready(out_ready),
    .result(res[3]), .op_err(oerr[3]));

  typedef struct {
    logic [31:0] x;
    logic [31:0] sh;
    logic [1:0]  op;
    logic [31:0] e_sat;
    logic [31:0] e_msk;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_sh(
    input logic [31:0] x,
    input logic [31:0] s,
    input logic [1:0]  o
  );
    if (o == 2'b10) return 32'h0;
    if (s >= 32) return (o == 2'b11) ? {32{x[31]}} : 32'h0;
    if (o == 2'b00) return x << s[4:0];
    if (o == 2'b01) return x >> s[4:0];
    return $signed(x) >>> s[4:0];
  endfunction

  task automatic run_vec(input int id,
                         input logic [31:0] x,
                         input logic [31:0] s,
                         input logic [1:0]  o,
                         input logic [31:0] es,
                         input logic [31:0] em);
    int          lat [4];
    logic [31:0] r [4];
    logic        e [4];
    for (int d = 0; d < 4; d++) begin
      lat[d] = 0;
      r[d] = 'x;
      e[d] = 1'bx;
    end
    @(negedge clk);
    chk($sformatf("v%0d in_ready", id), {28'd0, irdy}, 32'hF);
    X = x;
    shift = s;
    op = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (ov[d] && lat[d] == 0) begin
          lat[d] = c;
          r[d] = res[d];
          e[d] = oerr[d];
        end
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("v%0d u%0d result", id, d),
          r[d], (d == 1) ? em : es);
      chk($sformatf("v%0d u%0d latency", id, d),
          32'(lat[d]), (o == 2'b10) ? 32'd1 : 32'(exp_lat[d]));
      chk($sformatf("v%0d u%0d op_err", id, d),
          {31'd0, e[d]}, {31'd0, o == 2'b10});
    end
  endtask

  task automatic drain();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [31:0] sx [4];
    logic [31:0] ss [4];
    logic [1:0]  so [4];
    int          acc [4];
    int          n;
    logic        any;

    vecs[0]  = '{32'h00000001, 32'd2,  2'b01, 32'h00000000, 32'h00000000};
    vecs[1]  = '{32'h00000001, 32'd2,  2'b00, 32'h00000004, 32'h00000004};
    vecs[2]  = '{32'h80000000, 32'd31, 2'b01, 32'h00000001, 32'h00000001};
    vecs[3]  = '{32'h80000000, 32'd31, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{32'hA5A5A5A5, 32'd16, 2'b11, 32'hFFFFA5A5, 32'hFFFFA5A5};
    vecs[5]  = '{32'h12345678, 32'h20, 2'b01, 32'h00000000, 32'h12345678};
    vecs[6]  = '{32'h80000000, 32'h20, 2'b11, 32'hFFFFFFFF, 32'h80000000};
    vecs[7]  = '{32'hFFFFFFFF, 32'd0,  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[8]  = '{32'hFFFFFFFF, 32'd3,  2'b10, 32'h00000000, 32'h00000000};
    vecs[9]  = '{32'h55555555, 32'd1,  2'b01, 32'h2AAAAAAA, 32'h2AAAAAAA};
    vecs[10] = '{32'h12345678, 32'd4,  2'b00, 32'h23456780, 32'h23456780};
    vecs[11] = '{32'hF0000000, 32'h104, 2'b11, 32'hFFFFFFFF, 32'hFF000000};
    vecs[12] = '{32'h0000FFFF, 32'h23, 2'b00, 32'h00000000, 32'h0007FFF8};

    repeat (2) @(negedge clk);
    chk("rst out_valid", {28'd0, ov}, 32'h0);
    chk("rst op_err", {28'd0, oerr}, 32'h0);
    chk("rst in_ready", {28'd0, irdy}, 32'h0);
    for (int d = 0; d < 4; d++)
      chk($sformatf("rst u%0d result", d), res[d], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst in_ready", {28'd0, irdy}, 32'hF);

    for (int i = 0; i < 13; i++)
      run_vec(i, vecs[i].x, vecs[i].sh, vecs[i].op,
              vecs[i].e_sat, vecs[i].e_msk);

    out_ready = 1'b0;
    @(negedge clk);
    X = 32'h12345678;
    shift = 32'd8;
    op = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    X = 32'hDEADBEEF;
    shift = 32'd4;
    op = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[0] && n < 20);
    chk("bp reach", {31'd0, ov[0]}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp out_valid", {31'd0, ov[0]}, 32'd1);
      chk("bp result", res[0], 32'h00123456);
      chk("bp in_ready", {31'd0, irdy[0]}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp release out_valid", {31'd0, ov[0]}, 32'd0);
    chk("bp release in_ready", {31'd0, irdy[0]}, 32'd1);
    drain();

    sx = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h80000001, 32'h0F0F0F0F};
    ss = '{32'd4, 32'd4, 32'h1F, 32'h40};
    so = '{2'b00, 2'b11, 2'b01, 2'b00};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      X = sx[i];
      shift = ss[i];
      op = so[i];
      in_valid = 1'b1;
      n = 0;
      while (!irdy[0] && n < 20) begin
        @(negedge clk);
        n++;
      end
      acc[i] = cyc;
      @(posedge clk);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ov[0] && n < 20);
      chk($sformatf("stream %0d", i), res[0],
          ref_sh(sx[i], ss[i], so[i]));
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++)
      chk($sformatf("stream spacing %0d", i),
          32'(acc[i] - acc[i-1]), 32'd7);
    drain();

    @(negedge clk);
    X = 32'h0F0F0F0F;
    shift = 32'd4;
    op = 2'b00;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush out_valid", {31'd0, ov[0]}, 32'd0);
    chk("flush in_ready", {31'd0, irdy[0]}, 32'd1);
    chk("flush op_err", {31'd0, oerr[0]}, 32'd0);
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any = any | ov[0];
    end
    chk("flush no output", {31'd0, any}, 32'd0);

    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    X = 32'hCAFEF00D;
    op = 2'b01;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush idle in_ready", {31'd0, irdy[0]}, 32'd1);
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any = any | ov[0];
    end
    chk("flush blocks accept", {31'd0, any}, 32'd0);
    run_vec(100, 32'h55555555, 32'd1, 2'b01,
            32'h2AAAAAAA, 32'h2AAAAAAA);

    @(negedge clk);
    X = 32'h12345678;
    shift = 32'd3;
    op = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", {28'd0, ov}, 32'h0);
    chk("arst result", res[0], 32'h0);
    chk("arst in_ready", {31'd0, irdy[0]}, 32'd0);
    chk("arst op_err", {28'd0, oerr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst release in_ready", {31'd0, irdy[0]}, 32'd1);
    run_vec(101, 32'h55555555, 32'd1, 2'b01,
            32'h2AAAAAAA, 32'h2AAAAAAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
